// File: rtl/sha256_pkg.sv
// Shared types and sizes for the SHA-256 host-side loader.
package sha256_pkg;

  localparam int HASH_WORDS = 8;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_READ,
    S_DRAIN
  } state_t;

endpackage

// File: rtl/sha256_host_loader.sv
// Host-side loader: streams a message into the shared RAM, kicks the engine,
// then reads the 8-word digest back and streams it out.
//
// state       | meaning
// S_IDLE      | waiting for message word 0
// S_LOAD      | writing message words 1..N-1
// S_START     | core_start pulse cycle
// S_WAIT_BUSY | waiting for engine done to drop (done is high while idle)
// S_WAIT_DONE | waiting for engine done to rise
// S_READ      | issuing 8 digest reads, capturing one cycle behind
// S_DRAIN     | presenting digest words h0..h7 downstream
module sha256_host_loader
  import sha256_pkg::*;
#(
  parameter int                NUM_OF_WORDS = 20,
  parameter logic [ADDR_W-1:0] MSG_ADDR     = 16'h0000,
  parameter logic [ADDR_W-1:0] OUT_ADDR     = 16'h0100
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              core_start,
  input  logic              core_done,
  output logic [ADDR_W-1:0] message_addr,
  output logic [ADDR_W-1:0] output_addr,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              hash_valid,
  input  logic              hash_ready,
  output logic [DATA_W-1:0] hash_data,
  output logic              hash_last,
  output logic              busy
);

  localparam int              WCW    = $clog2(NUM_OF_WORDS + 1);
  localparam logic [WCW-1:0]  LAST_W = WCW'(NUM_OF_WORDS - 1);

  state_t            state, state_nxt;
  logic [WCW-1:0]    wcnt;
  logic [3:0]        rcnt;
  logic [2:0]        ocnt;
  logic [DATA_W-1:0] hbuf [HASH_WORDS];
  logic              accept, last_word, read_done, hash_take;

  assign mem_clk      = clk;
  assign message_addr = MSG_ADDR;
  assign output_addr  = OUT_ADDR;
  assign busy         = (state != S_IDLE);
  assign accept       = in_valid & in_ready;
  // wcnt is 0 in IDLE, so this also covers the single-word job
  assign last_word    = (wcnt == LAST_W);
  assign read_done    = (rcnt == 4'(HASH_WORDS));
  assign hash_take    = hash_valid & hash_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    case (state)
      S_IDLE, S_LOAD: begin
        if (accept) begin
          mem_we         = 1'b1;
          mem_addr       = MSG_ADDR + ADDR_W'(wcnt);
          mem_write_data = in_data;
          state_nxt      = last_word ? S_START : S_LOAD;
        end
      end
      S_START:     state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!core_done) state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (core_done)  state_nxt = S_READ;
      S_READ: begin
        if (!rcnt[3]) mem_addr = OUT_ADDR + ADDR_W'(rcnt);
        if (read_done) state_nxt = S_DRAIN;
      end
      S_DRAIN:     if (hash_take && ocnt == 3'd7) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // in_ready is registered from the next state, so it is low for the first
  // cycle after reset release and drops the cycle after the last word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready   <= 1'b0;
      core_start <= 1'b0;
      wcnt       <= '0;
      rcnt       <= '0;
      ocnt       <= '0;
      hash_valid <= 1'b0;
      hash_last  <= 1'b0;
      hash_data  <= '0;
      for (int i = 0; i < HASH_WORDS; i++) hbuf[i] <= '0;
    end else begin
      in_ready   <= (state_nxt == S_IDLE) || (state_nxt == S_LOAD);
      core_start <= (state_nxt == S_START);
      if (accept) wcnt <= last_word ? '0 : wcnt + 1'b1;
      rcnt <= (state == S_READ && !read_done) ? rcnt + 4'd1 : 4'd0;
      if (state == S_READ && rcnt != 4'd0) hbuf[3'(rcnt - 4'd1)] <= mem_read_data;

      if (state == S_READ && read_done) begin
        hash_valid <= 1'b1;
        hash_data  <= hbuf[0];
        hash_last  <= 1'b0;
        ocnt       <= '0;
      end else if (state == S_DRAIN && hash_take) begin
        if (ocnt == 3'd7) begin
          hash_valid <= 1'b0;
          hash_last  <= 1'b0;
          ocnt       <= '0;
        end else begin
          ocnt      <= ocnt + 3'd1;
          hash_data <= hbuf[ocnt + 3'd1];
          hash_last <= (ocnt == 3'd6);
        end
      end
    end
  end

endmodule

// File: tb/tb_sha256_host_loader.sv
// Self-checking bench for sha256_host_loader with a RAM model and engine stub.
module tb_sha256_host_loader;

  localparam int          N   = 20;
  localparam logic [15:0] MSG = 16'h0000;
  localparam logic [15:0] OUT = 16'h0100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        core_start;
  logic        core_done = 1'b1;
  logic [15:0] message_addr, output_addr;
  logic        mem_clk, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data = '0;
  logic        hash_valid;
  logic        hash_ready = 1'b0;
  logic [31:0] hash_data;
  logic        hash_last;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sha256_host_loader #(.NUM_OF_WORDS(N), .MSG_ADDR(MSG), .OUT_ADDR(OUT)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .core_start(core_start), .core_done(core_done),
    .message_addr(message_addr), .output_addr(output_addr), .mem_clk(mem_clk),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .hash_valid(hash_valid), .hash_ready(hash_ready),
    .hash_data(hash_data), .hash_last(hash_last), .busy(busy)
  );

  // Shared RAM plus engine stub: after core_start, done falls fall_delay+1
  // edges later, stays low run_len cycles, then the digest appears at OUT.
  logic [31:0] mem [0:65535];
  int          run_len = 100;
  int          fall_delay = 0;
  logic [31:0] hash_base = 32'hA000_0000;
  logic        eng_active = 1'b0;
  int          eng_timer = 0;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_write_data;
    mem_read_data <= mem[mem_addr];
    if (core_start) begin
      eng_active <= 1'b1;
      eng_timer  <= 0;
    end else if (eng_active) begin
      eng_timer <= eng_timer + 1;
      if (eng_timer == fall_delay) core_done <= 1'b0;
      if (eng_timer == fall_delay + run_len) begin
        for (int k = 0; k < 8; k++) mem[32'(OUT) + k] <= hash_base + 32'(k);
        core_done  <= 1'b1;
        eng_active <= 1'b0;
      end
    end
  end

  // Passive observation logs sampled on the falling edge.
  int          cyc = 0;
  logic [47:0] wr_log [$];
  int          wr_cyc [$];
  logic [31:0] hash_log [$];
  logic        last_log [$];
  int          start_cnt = 0, hv_cnt = 0, stall_viol = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (mem_we) begin
      wr_log.push_back({mem_addr, mem_write_data});
      wr_cyc.push_back(cyc);
    end
    if (core_start) start_cnt++;
    if (hash_valid) hv_cnt++;
    if (hash_valid && hash_ready) begin
      hash_log.push_back(hash_data);
      last_log.push_back(hash_last);
    end
    if (prev_stall && reset_n && (hash_valid !== 1'b1 || hash_data !== prev_data)) stall_viol++;
    prev_stall = hash_valid && !hash_ready;
    prev_data  = hash_data;
  end

  task automatic load_words(input logic [31:0] w[$], input int gap_pct, output bit tmo);
    int t;
    tmo = 1'b0;
    @(posedge clk); #1;
    foreach (w[i]) begin
      for (int g = 0; g < 3; g++)
        if ($urandom_range(0, 99) < gap_pct) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      in_valid = 1'b1;
      in_data  = w[i];
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        tmo = 1'b1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int ready_pct, output bit tmo);
    int t = 0;
    int base = hash_log.size();
    tmo = 1'b0;
    while (hash_log.size() < base + 8 && t < 5000) begin
      @(posedge clk); #1;
      hash_ready = ($urandom_range(0, 99) < ready_pct);
      t++;
    end
    in_valid = 1'b0;
    if (hash_log.size() < base + 8) tmo = 1'b1;
    @(posedge clk); #1;
    hash_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({in_ready, busy, hash_valid, mem_we, core_start, hash_last} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 000000", {in_ready, busy, hash_valid, mem_we, core_start, hash_last});
    end
    n_tests++;
    if ({mem_addr, mem_write_data, hash_data} !== 80'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", {mem_addr, mem_write_data, hash_data});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({in_ready, busy, hash_valid, mem_we, core_start} !== 5'b10000) begin
      n_fail++;
      $display("FAIL idle_ctl: got %b want 10000", {in_ready, busy, hash_valid, mem_we, core_start});
    end
    n_tests++;
    if (message_addr !== MSG || output_addr !== OUT) begin
      n_fail++;
      $display("FAIL const_addr: got %h/%h want %h/%h", message_addr, output_addr, MSG, OUT);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[$];
    bit t1, t2;
    int wb = wr_log.size(), sb = start_cnt, hb = hash_log.size();
    for (int i = 0; i < N; i++) w.push_back(32'(i));
    hash_base = 32'hA000_0000; run_len = 100; fall_delay = 0;
    load_words(w, 0, t1);
    @(negedge clk);
    n_tests++;
    if ({in_ready, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_ready_after_last: got %b want 01", {in_ready, busy});
    end
    drain(100, t2);
    n_tests++;
    if ({t1, t2} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_timeout: got %b want 00", {t1, t2});
    end
    n_tests++;
    if (wr_log.size() - wb !== N) begin
      n_fail++;
      $display("FAIL b2b_wr_count: got %0d want %0d", wr_log.size() - wb, N);
    end else begin
      for (int i = 0; i < N; i++) begin
        n_tests++;
        if (wr_log[wb + i] !== {MSG + 16'(i), w[i]} || wr_cyc[wb + i] !== wr_cyc[wb] + i) begin
          n_fail++;
          $display("FAIL b2b_wr[%0d]: got %h @%0d want %h @%0d", i, wr_log[wb + i], wr_cyc[wb + i],
                   {MSG + 16'(i), w[i]}, wr_cyc[wb] + i);
        end
      end
    end
    n_tests++;
    if (start_cnt - sb !== 1) begin
      n_fail++;
      $display("FAIL b2b_start_cycles: got %0d want 1", start_cnt - sb);
    end
    for (int k = 0; k < 8 && hb + k < hash_log.size(); k++) begin
      n_tests++;
      if (hash_log[hb + k] !== hash_base + 32'(k) || last_log[hb + k] !== (k == 7)) begin
        n_fail++;
        $display("FAIL b2b_hash[%0d]: got %h last=%b want %h last=%b", k, hash_log[hb + k],
                 last_log[hb + k], hash_base + 32'(k), (k == 7));
      end
    end
  endtask

  task automatic test_gaps_and_stalls();
    logic [31:0] w[$];
    bit t1, t2;
    int wb = wr_log.size(), hb = hash_log.size(), sv = stall_viol;
    for (int i = 0; i < N; i++) w.push_back($urandom);
    hash_base = $urandom; run_len = 20 + $urandom_range(0, 30); fall_delay = 0;
    load_words(w, 40, t1);
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    drain(50, t2);
    n_tests++;
    if ({t1, t2} !== 2'b00) begin
      n_fail++;
      $display("FAIL gap_timeout: got %b want 00", {t1, t2});
    end
    n_tests++;
    if (wr_log.size() - wb !== N) begin
      n_fail++;
      $display("FAIL gap_wr_count: got %0d want %0d", wr_log.size() - wb, N);
    end
    for (int i = 0; i < N; i++) begin
      n_tests++;
      if (mem[32'(MSG) + i] !== w[i]) begin
        n_fail++;
        $display("FAIL gap_mem[%0d]: got %h want %h", i, mem[32'(MSG) + i], w[i]);
      end
    end
    n_tests++;
    if (stall_viol - sv !== 0) begin
      n_fail++;
      $display("FAIL gap_stall_stable: got %0d violations want 0", stall_viol - sv);
    end
    for (int k = 0; k < 8 && hb + k < hash_log.size(); k++) begin
      n_tests++;
      if (hash_log[hb + k] !== hash_base + 32'(k) || last_log[hb + k] !== (k == 7)) begin
        n_fail++;
        $display("FAIL gap_hash[%0d]: got %h last=%b want %h last=%b", k, hash_log[hb + k],
                 last_log[hb + k], hash_base + 32'(k), (k == 7));
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] w[$];
    bit t1, t2, t3;
    int t, hvb, wb, hb;
    for (int i = 0; i < N; i++) w.push_back($urandom);
    hash_base = 32'hC000_0000; run_len = 60; fall_delay = 0;
    load_words(w, 0, t1);
    t = 0;
    @(negedge clk);
    while (core_done && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    n_tests++;
    if ({core_done, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL abort_in_wait: got done,busy=%b want 01", {core_done, busy});
    end
    hvb = hv_cnt;
    @(posedge clk); #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    t = 0;
    while (eng_active && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (20) @(negedge clk);
    n_tests++;
    if ({busy, hv_cnt - hvb} !== {1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL abort_no_hash: got busy=%b hv=%0d want busy=0 hv=0", busy, hv_cnt - hvb);
    end
    w.delete();
    for (int i = 0; i < N; i++) w.push_back($urandom);
    hash_base = 32'hC100_0000; run_len = 30;
    wb = wr_log.size(); hb = hash_log.size();
    load_words(w, 10, t2);
    drain(70, t3);
    n_tests++;
    if ({t1, t2, t3} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_timeout: got %b want 000", {t1, t2, t3});
    end
    n_tests++;
    if (wr_log.size() - wb !== N || wr_log[wb] !== {MSG, w[0]}) begin
      n_fail++;
      $display("FAIL abort_rejob_wr: got n=%0d first=%h want n=%0d first=%h", wr_log.size() - wb,
               wr_log[wb], N, {MSG, w[0]});
    end
    for (int k = 0; k < 8 && hb + k < hash_log.size(); k++) begin
      n_tests++;
      if (hash_log[hb + k] !== hash_base + 32'(k) || last_log[hb + k] !== (k == 7)) begin
        n_fail++;
        $display("FAIL abort_hash[%0d]: got %h last=%b want %h last=%b", k, hash_log[hb + k],
                 last_log[hb + k], hash_base + 32'(k), (k == 7));
      end
    end
  endtask

  task automatic test_early_done();
    logic [31:0] w[$];
    bit t1, t2;
    int hb = hash_log.size(), sb = start_cnt;
    for (int i = 0; i < N; i++) w.push_back($urandom);
    hash_base = 32'hD000_0000; run_len = 10; fall_delay = 4;
    load_words(w, 0, t1);
    drain(100, t2);
    n_tests++;
    if ({t1, t2} !== 2'b00 || start_cnt - sb !== 1) begin
      n_fail++;
      $display("FAIL early_done_flow: got tmo=%b starts=%0d want tmo=00 starts=1", {t1, t2}, start_cnt - sb);
    end
    for (int k = 0; k < 8 && hb + k < hash_log.size(); k++) begin
      n_tests++;
      if (hash_log[hb + k] !== hash_base + 32'(k)) begin
        n_fail++;
        $display("FAIL early_done_hash[%0d]: got %h want %h", k, hash_log[hb + k], hash_base + 32'(k));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps_and_stalls();
    test_abort();
    test_early_done();
    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
